axi_lite_mult_table: RTL and testbench
======================================

# axi_lite_mult_table

- AXI4-Lite slave that serves a parametrised times table.
- A read address carries two WIDTH-bit operands; the read data returns their product after a fixed, parametrised pipeline latency.
- Successor to the fixed 3-bit multiplier: generalised operand width and latency, full AXI4-Lite read handshake with backpressure, and an optional write-accessible control register for signed mode.
- Sits as a leaf peripheral behind the team's AXI4-Lite interconnect.

## Interface
Parameters:
- WIDTH, 3, operand width in bits; 2*WIDTH ≤ DATA_W
- LATENCY, 2, multiply pipeline stages, ≥ 1
- DATA_W, 32, read/write data width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- araddr  in  2*WIDTH  {a, b}: a = araddr[2*WIDTH-1:WIDTH], b = araddr[WIDTH-1:0]
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  product, zero- or sign-extended
- rresp  out  2  always OKAY (2'b00)
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  4  write address
- awvalid / awready  in / out  1  write address handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  write byte strobes
- wvalid / wready  in / out  1  write data handshake
- bresp  out  2  OKAY or SLVERR (2'b10)
- bvalid / bready  out / in  1  write response handshake

## Operation
Read FSM:
- R_IDLE: arready=1. On arvalid&&arready, capture a, b and the current signed bit, then go to R_BUSY.
- R_BUSY: count LATENCY cycles, then go to R_RESP.
- R_RESP: rvalid=1; rdata and rresp held stable. On rvalid&&rready, go to R_IDLE.
- One outstanding read at a time.

Arithmetic:
- Unsigned: rdata = a*b, 2*WIDTH bits, zero-extended to DATA_W.
- Signed: operands are two's complement; the 2*WIDTH-bit product is sign-extended to DATA_W.

Write path:
- awready and wready are independent. AW and W may arrive in either order or in the same cycle.
- Each channel deasserts its ready once its beat is captured.
- When both beats are held, bvalid=1 on the next cycle.
- On bvalid&&bready, awready and wready return to 1.

Reset:
- All outputs are 0 while rst is high.
- arready, awready and wready go to 1 at the first edge with rst=0.
- rst asserted mid-transaction discards it: no rvalid or bvalid is produced, and the signed bit clears.

## Timing
- AR handshake at edge k: rvalid=1 after edge k+LATENCY.
- arready=0 from edge k until the edge after the R handshake.
- Minimum read period: LATENCY+2 cycles.
- rready low stalls indefinitely. rdata must not change while rvalid=1 && !rready.
- bvalid is asserted one cycle after the later of the AW and W handshakes.
- Simultaneous read and write: the signed bit is sampled at the AR handshake edge. A ctrl update on that same edge does not affect that read.
- arvalid asserted during rst is ignored. The master holds it, and it is accepted after reset.

## Configuration
- Macro: AXI_LITE_MULT_SIGNED_EN.
- Defined:
  - ctrl register at awaddr 0; bit0 = signed, updated only when wstrb[0]=1; bresp OKAY.
  - Any other awaddr: no update, bresp SLVERR.
- Undefined:
  - No ctrl register.
  - Write handshakes still complete; bresp is always SLVERR.
  - Multiplication is always unsigned.

## Structure
- Package axi_mult_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - CTRL_ADDR = 4'h0
  - Read FSM state enum {R_IDLE, R_BUSY, R_RESP}
- Sub-module mult_pipe: LATENCY-stage registered multiplier.
  - Carries a valid bit and the signed bit down the pipeline.
  - Output is sign/zero-extended to DATA_W.
  - Parent holds the final stage in a result register until the R handshake.

## Test plan
Bench parameters: WIDTH=3, LATENCY=2.
1. Reset: rst high 2 cycles with arvalid=1 -> all outputs 0; arready=1 at the first edge after release; the read is then accepted.
2. araddr={3'd3,3'd7}, rready=1 -> rdata=21, rvalid rises exactly 2 edges after the AR handshake, rresp=0.
3. araddr={3'd5,3'd6}, rready low for 5 cycles -> rdata=30 stable, rvalid=1, arready=0 throughout; R handshake on rready.
4. Write wdata=1, wstrb=1 to awaddr 0, W before AW, then read {3'd7,3'd3}:
   - With macro: bresp=OKAY, rdata=32'hFFFFFFFD.
   - Without macro: bresp=SLVERR, rdata=21.
5. All 64 {a,b} pairs back-to-back with random rready stalls -> every rdata equals the unsigned a*b; no lost or duplicated responses.
6. rst pulsed for 1 cycle in R_BUSY -> no rvalid follows; the next read {3'd2,3'd2} returns 4.

Source files
------------

// File: rtl/axi_mult_pkg.sv
// Shared constants and types for the AXI4-Lite times-table peripheral.
package axi_mult_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] CTRL_ADDR   = 4'h0;

  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_RESP} rstate_t;

endpackage

// File: rtl/mult_pipe.sv
// LATENCY-stage multiplier pipeline. Operands, signed flag and valid move
// down the stages; the product is formed from the last stage and extended
// to DATA_W (sign-extended in signed mode, zero-extended otherwise).
module mult_pipe #(
  parameter int WIDTH   = 3,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_sgn,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_prod
);

  logic [LATENCY:1]                  vld_pipe;
  logic [LATENCY:1]                  sgn_pipe;
  logic [LATENCY:1][WIDTH-1:0]       a_pipe;
  logic [LATENCY:1][WIDTH-1:0]       b_pipe;
  logic [2*WIDTH-1:0]                ea, eb, prod;

  // Valid shift register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Operand and mode shift registers (qualified by vld_pipe, no reset needed).
  always_ff @(posedge clk) begin
    a_pipe[1]   <= in_a;
    b_pipe[1]   <= in_b;
    sgn_pipe[1] <= in_sgn;
    for (int i = 2; i <= LATENCY; i++) begin
      a_pipe[i]   <= a_pipe[i-1];
      b_pipe[i]   <= b_pipe[i-1];
      sgn_pipe[i] <= sgn_pipe[i-1];
    end
  end

  // Extend operands to 2*WIDTH so one multiplier covers both modes; the low
  // 2*WIDTH bits of the product are exact in two's complement.
  always_comb begin
    ea   = {{WIDTH{sgn_pipe[LATENCY] & a_pipe[LATENCY][WIDTH-1]}}, a_pipe[LATENCY]};
    eb   = {{WIDTH{sgn_pipe[LATENCY] & b_pipe[LATENCY][WIDTH-1]}}, b_pipe[LATENCY]};
    prod = ea * eb;
    out_prod = sgn_pipe[LATENCY] ? DATA_W'($signed(prod)) : DATA_W'(prod);
  end

  assign out_vld = vld_pipe[LATENCY];

endmodule

// File: rtl/axi_lite_mult_table.sv
// AXI4-Lite slave returning a*b for araddr = {a, b} after LATENCY cycles.
// Build option AXI_LITE_MULT_SIGNED_EN adds a ctrl register at awaddr 0
// (bit0 = signed mode); without it every write completes with SLVERR.
module axi_lite_mult_table
  import axi_mult_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*WIDTH-1:0]  araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [3:0]          awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  rstate_t             state, state_nxt;
  logic                en;
  logic                ar_hs, sgn_cur;
  logic                pipe_vld;
  logic [DATA_W-1:0]   pipe_prod;
  logic                aw_held, w_held, wr_fire, wr_ok;
  logic [3:0]          awaddr_q;
  logic                w_bit, w_stb;
  logic                unused_ok;

  // Readies stay low through reset and rise on the first edge out of it.
  always_ff @(posedge clk) begin
    if (rst) en <= 1'b0;
    else     en <= 1'b1;
  end

  assign arready = en && (state == R_IDLE);
  assign rvalid  = (state == R_RESP);
  assign rresp   = RESP_OKAY;
  assign ar_hs   = arvalid && arready;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nxt;
  end

  // Read FSM next state; the pipe valid marks the end of the busy window.
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (ar_hs)    state_nxt = R_BUSY;
      R_BUSY:  if (pipe_vld) state_nxt = R_RESP;
      R_RESP:  if (rready)   state_nxt = R_IDLE;
      default:               state_nxt = R_IDLE;
    endcase
  end

  mult_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DATA_W(DATA_W)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (ar_hs),
    .in_a     (araddr[2*WIDTH-1:WIDTH]),
    .in_b     (araddr[WIDTH-1:0]),
    .in_sgn   (sgn_cur),
    .out_vld  (pipe_vld),
    .out_prod (pipe_prod)
  );

  // Result register: holds rdata stable until the R handshake.
  always_ff @(posedge clk) begin
    if (rst)                                rdata <= '0;
    else if (state == R_BUSY && pipe_vld)   rdata <= pipe_prod;
  end

  assign awready = en && !aw_held;
  assign wready  = en && !w_held;
  assign wr_fire = aw_held && w_held && !bvalid;

  // Write path: capture each beat independently, respond once both are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      awaddr_q <= '0;
      w_bit    <= 1'b0;
      w_stb    <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        w_bit  <= wdata[0];
        w_stb  <= wstrb[0];
      end
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (bvalid && bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

`ifdef AXI_LITE_MULT_SIGNED_EN
  logic sgn_q;

  assign wr_ok   = (awaddr_q == CTRL_ADDR);
  assign sgn_cur = sgn_q;

  // Ctrl register; updated on the write-response edge, so a read accepted on
  // that same edge still sees the old mode.
  always_ff @(posedge clk) begin
    if (rst)                           sgn_q <= 1'b0;
    else if (wr_fire && wr_ok && w_stb) sgn_q <= w_bit;
  end
`else
  assign wr_ok   = 1'b0;
  assign sgn_cur = 1'b0;
`endif

  // Only bit0/strobe0 and the address matter; the remaining bits are sunk here.
  assign unused_ok = ^{awaddr, wdata, wstrb, awaddr_q, w_bit, w_stb};

endmodule

// File: tb/tb_axi_lite_mult_table.sv
// Randomized self-checking bench for axi_lite_mult_table (WIDTH=3, LATENCY=2).
// Honors AXI_LITE_MULT_SIGNED_EN in its reference model.
module tb_axi_lite_mult_table;

  localparam int WIDTH   = 3;
  localparam int LATENCY = 2;
  localparam int DATA_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*WIDTH-1:0]  araddr;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;
  logic [3:0]          awaddr;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_sgn = 1'b0;

  always #5 clk = ~clk;

  axi_lite_mult_table #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: integer product of the operands, interpreted per mode.
  function automatic logic [31:0] ref_mul(input int a, input int b, input bit sgn);
    int sa, sb;
    sa = a;
    sb = b;
    if (sgn) begin
      if (a >= (1 << (WIDTH-1))) sa = a - (1 << WIDTH);
      if (b >= (1 << (WIDTH-1))) sb = b - (1 << WIDTH);
    end
    return 32'(sa * sb);
  endfunction

  task automatic do_read(input int a, input int b, input int stall);
    logic [31:0] exp;
    string       t;
    int          e;
    exp = ref_mul(a, b, model_sgn);
    t = $sformatf("rd %0d*%0d", a, b);
    araddr  = {WIDTH'(a), WIDTH'(b)};
    arvalid = 1'b1;
    e = 0;
    while (!arready && e < 20) begin tick; e++; end
    if (!arready) begin
      chk({t, " ar_timeout"}, 0, 1);
      arvalid = 1'b0;
      return;
    end
    tick;
    arvalid = 1'b0;
    chk({t, " ar_busy"}, {63'd0, arready}, 0);
    e = 0;
    while (!rvalid && e < 20) begin tick; e++; end
    chk({t, " latency"}, e, LATENCY);
    chk({t, " rdata"}, rdata, exp);
    chk({t, " rresp"}, rresp, 0);
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({t, " stall {rvalid,arready,rdata}"}, {rvalid, arready, rdata}, {2'b10, exp});
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk({t, " after_r {rvalid,arready}"}, {rvalid, arready}, 2'b01);
  endtask

  // order: 0 = AW and W together, 1 = W first, 2 = AW first
  task automatic do_write(input int addr, input int data, input int strb, input int order);
    logic [1:0] exp_resp;
    string      t;
    bit         aw_pend, w_pend, awhs, whs;
    int         cyc;
    t = $sformatf("wr a=%0d d=%0d s=%0d o=%0d", addr, data, strb, order);
    awaddr  = 4'(addr);
    wdata   = 32'(data);
    wstrb   = 4'(strb);
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    awvalid = (order != 1);
    wvalid  = (order != 2);
    cyc = 0;
    while ((aw_pend || w_pend) && cyc < 20) begin
      awhs = awvalid && awready;
      whs  = wvalid && wready;
      tick;
      cyc++;
      if (awhs) aw_pend = 1'b0;
      if (whs)  w_pend  = 1'b0;
      if (!aw_pend || !w_pend) begin
        awvalid = aw_pend;
        wvalid  = w_pend;
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (aw_pend || w_pend) begin
      chk({t, " hs_timeout"}, 0, 1);
      return;
    end
    chk({t, " b_early"}, {63'd0, bvalid}, 0);
    tick;
    chk({t, " bvalid"}, {63'd0, bvalid}, 1);
`ifdef AXI_LITE_MULT_SIGNED_EN
    exp_resp = (addr == 0) ? 2'b00 : 2'b10;
    if (addr == 0 && strb[0]) model_sgn = data[0];
`else
    exp_resp = 2'b10;
`endif
    chk({t, " bresp"}, bresp, exp_resp);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk({t, " after_b {bvalid,awready,wready}"}, {bvalid, awready, wready}, 3'b011);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    araddr = {3'd3, 3'd7};
    arvalid = 1'b1;
    rready = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;

    // Reset with a read request pending
    tick;
    tick;
    chk("rst ready/valid", {arready, rvalid, awready, wready, bvalid}, 0);
    chk("rst rdata", rdata, 0);
    chk("rst resp", {rresp, bresp}, 0);
    rst = 1'b0;
    tick;
    chk("rst release arready", {arready, awready, wready}, 3'b111);
    do_read(3, 7, 0);

    // Long backpressure
    do_read(5, 6, 5);

    // Ctrl write W before AW, then signed-sensitive read
    do_write(0, 1, 1, 1);
    do_read(7, 3, 0);
    do_write(0, 0, 1, 0);
    do_write(4, 1, 1, 2);
    do_read(7, 3, 0);
    do_write(0, 1, 0, 0);
    do_read(7, 7, 0);

    // Full table, unsigned, random stalls
    do_write(0, 0, 1, 0);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        do_read(a, b, $urandom_range(0, 3));

    // Random mix of ctrl writes and reads
    for (int i = 0; i < 16; i++) begin
      do_write(($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0,
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 2));
      do_read($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2));
    end

    // Reset while the read is busy
    do_write(0, 1, 1, 0);
    araddr  = {3'd3, 3'd3};
    arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_sgn = 1'b0;
    chk("midrst outputs", {arready, rvalid, bvalid}, 0);
    tick;
    chk("midrst arready", {63'd0, arready}, 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= rvalid;
      tick;
    end
    chk("midrst no rvalid", {63'd0, seen}, 0);
    do_read(2, 2, 0);
    do_read(7, 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
